// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one column driven per scan step, debounced press/release, hex key code out.
// Optional auto-repeat while a key stays held: define KEY_REPEAT_EN.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// SCAN     | walking the columns, waiting for a single low row
// DEBOUNCE | column frozen, counting identical samples of the candidate key
// HELD     | key accepted, column frozen, counting all-high samples to release
module keypad_scanner #(
  parameter int DEBOUNCE_CNT = 3
`ifdef KEY_REPEAT_EN
  , parameter int REPEAT_DELAY = 10
  , parameter int REPEAT_RATE  = 4
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  localparam logic [3:0] LP_DEB = 4'(DEBOUNCE_CNT);

  state_t     r_state, w_state_nxt;
  logic       r_sclk_s1, r_sclk_s2, r_sclk_prev, r_step;
  logic [3:0] r_row_s1, r_row_s2;
  logic [1:0] r_col, w_col_nxt;
  logic [3:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [1:0] r_cand, w_cand_nxt;
  logic [3:0] r_code, w_code_nxt;
  logic       r_valid, w_valid_nxt;
  logic       r_held, w_held_nxt;
  logic       w_single, w_accept;
  logic [1:0] w_row_idx;
`ifdef KEY_REPEAT_EN
  localparam logic [7:0] LP_RPT_DLY = 8'(REPEAT_DELAY);
  localparam logic [7:0] LP_RPT_RLD = 8'(REPEAT_DELAY - REPEAT_RATE);
  logic [7:0] r_rpt, w_rpt_nxt, w_rpt_inc;
  assign w_rpt_inc = r_rpt + 8'd1;
`endif

  function automatic logic [3:0] key_map(input logic [1:0] col, input logic [1:0] row);
    logic [3:0] code;
    case ({col, row})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h4;
      4'b00_10: code = 4'h7;
      4'b00_11: code = 4'h0;
      4'b01_00: code = 4'h2;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h8;
      4'b01_11: code = 4'hF;
      4'b10_00: code = 4'h3;
      4'b10_01: code = 4'h6;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hE;
      4'b11_00: code = 4'hA;
      4'b11_01: code = 4'hB;
      4'b11_10: code = 4'hC;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  // Sync flops reset high so an sclk already high at reset release is not seen as an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sclk_s1   <= 1'b1;
      r_sclk_s2   <= 1'b1;
      r_sclk_prev <= 1'b1;
      r_step      <= 1'b0;
      r_row_s1    <= 4'hF;
      r_row_s2    <= 4'hF;
    end else begin
      r_sclk_s1   <= sclk;
      r_sclk_s2   <= r_sclk_s1;
      r_sclk_prev <= r_sclk_s2;
      r_step      <= r_sclk_s2 & ~r_sclk_prev;
      r_row_s1    <= row_n;
      r_row_s2    <= r_row_s1;
    end
  end

  always_comb begin
    w_single  = 1'b1;
    w_row_idx = 2'd0;
    case (r_row_s2)
      4'b1110: w_row_idx = 2'd0;
      4'b1101: w_row_idx = 2'd1;
      4'b1011: w_row_idx = 2'd2;
      4'b0111: w_row_idx = 2'd3;
      default: w_single  = 1'b0;
    endcase
  end

  assign w_cnt_inc = r_cnt + 4'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_cnt_nxt   = r_cnt;
    w_cand_nxt  = r_cand;
    w_code_nxt  = r_code;
    w_valid_nxt = 1'b0;
    w_held_nxt  = r_held;
    w_accept    = 1'b0;
`ifdef KEY_REPEAT_EN
    w_rpt_nxt   = r_rpt;
`endif
    if (r_step) begin
      case (r_state)
        ST_SCAN: begin
          if (w_single) begin
            w_cand_nxt = w_row_idx;
            w_cnt_nxt  = 4'd1;
            if (LP_DEB == 4'd1) w_accept = 1'b1;
            else                w_state_nxt = ST_DEBOUNCE;
          end else begin
            w_col_nxt = r_col + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (w_single && (w_row_idx == r_cand)) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == LP_DEB) w_accept = 1'b1;
          end else begin
            w_cnt_nxt   = 4'd0;
            w_col_nxt   = r_col + 2'd1;
            w_state_nxt = ST_SCAN;
          end
        end
        ST_HELD: begin
          if (r_row_s2 == 4'hF) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == LP_DEB) begin
              w_held_nxt  = 1'b0;
              w_cnt_nxt   = 4'd0;
              w_col_nxt   = r_col + 2'd1;
              w_state_nxt = ST_SCAN;
            end
          end else begin
            w_cnt_nxt = 4'd0;
          end
`ifdef KEY_REPEAT_EN
          // Reload below the delay so later repeats come every REPEAT_RATE steps.
          if (w_single && (w_row_idx == r_cand)) begin
            w_rpt_nxt = w_rpt_inc;
            if (w_rpt_inc == LP_RPT_DLY) begin
              w_valid_nxt = 1'b1;
              w_rpt_nxt   = LP_RPT_RLD;
            end
          end else begin
            w_rpt_nxt = 8'd0;
          end
`endif
        end
        default: w_state_nxt = ST_SCAN;
      endcase
    end
    if (w_accept) begin
      w_code_nxt  = key_map(r_col, w_row_idx);
      w_valid_nxt = 1'b1;
      w_held_nxt  = 1'b1;
      w_cnt_nxt   = 4'd0;
      w_state_nxt = ST_HELD;
`ifdef KEY_REPEAT_EN
      w_rpt_nxt   = 8'd0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_SCAN;
      r_col   <= 2'd0;
      r_cnt   <= 4'd0;
      r_cand  <= 2'd0;
      r_code  <= 4'd0;
      r_valid <= 1'b0;
      r_held  <= 1'b0;
`ifdef KEY_REPEAT_EN
      r_rpt   <= 8'd0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_col   <= w_col_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cand  <= w_cand_nxt;
      r_code  <= w_code_nxt;
      r_valid <= w_valid_nxt;
      r_held  <= w_held_nxt;
`ifdef KEY_REPEAT_EN
      r_rpt   <= w_rpt_nxt;
`endif
    end
  end

  assign col_n     = ~(4'b0001 << r_col);
  assign key_code  = r_code;
  assign key_valid = r_valid;
  assign key_held  = r_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: column walk, debounce, release, ghosts, reset, key map and repeat.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclk;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  always #5 clk = ~clk;

  keypad_scanner dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  int checks       = 0;
  int failures     = 0;
  int vcount       = 0;
  int step_idx     = 0;
  int double_valid = 0;
  int vsteps[$];
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      vcount++;
      vsteps.push_back(step_idx);
      if (prev_valid) double_valid++;
    end
    prev_valid = (key_valid === 1'b1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_step(input logic [3:0] rows);
    row_n = rows;
    repeat (4) @(negedge clk);
    step_idx++;
    sclk = 1'b1;
    repeat (6) @(negedge clk);
    sclk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  function automatic logic [3:0] key_rows(input int kc, input int kr);
    logic [3:0] r;
    r = 4'hF;
    if (col_n[kc] == 1'b0) r[kr] = 1'b0;
    return r;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic [3:0] rows;
    logic [3:0] exp_col;
  } col_vec_t;

  typedef struct {
    int         kc;
    int         kr;
    logic [3:0] code;
  } key_vec_t;

  col_vec_t cv[8];
  key_vec_t km[16];
  int       rpt_exp[7];

  initial begin
    int v0;
    int n;
    int acc;
    int qstart;

    cv[0] = '{4'hF, 4'b1101}; cv[1] = '{4'hF, 4'b1011};
    cv[2] = '{4'hF, 4'b0111}; cv[3] = '{4'hF, 4'b1110};
    cv[4] = '{4'hF, 4'b1101}; cv[5] = '{4'hF, 4'b1011};
    cv[6] = '{4'hF, 4'b0111}; cv[7] = '{4'hF, 4'b1110};

    km[0]  = '{0, 0, 4'h1}; km[1]  = '{0, 1, 4'h4}; km[2]  = '{0, 2, 4'h7}; km[3]  = '{0, 3, 4'h0};
    km[4]  = '{1, 0, 4'h2}; km[5]  = '{1, 1, 4'h5}; km[6]  = '{1, 2, 4'h8}; km[7]  = '{1, 3, 4'hF};
    km[8]  = '{2, 0, 4'h3}; km[9]  = '{2, 1, 4'h6}; km[10] = '{2, 2, 4'h9}; km[11] = '{2, 3, 4'hE};
    km[12] = '{3, 0, 4'hA}; km[13] = '{3, 1, 4'hB}; km[14] = '{3, 2, 4'hC}; km[15] = '{3, 3, 4'hD};

    rpt_exp = '{0, 10, 14, 18, 22, 26, 30};

    // Reset with sclk already high: no step may follow.
    rst_n = 1'b0;
    sclk  = 1'b1;
    row_n = 4'hF;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_col", col_n, 4'b1110);
    check("rst_code", key_code, 4'h0);
    check("rst_held", key_held, 1'b0);
    check("rst_valid_cnt", vcount, 0);
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_sclk_fall_col", col_n, 4'b1110);

    for (int i = 0; i < 8; i++) begin
      do_step(cv[i].rows);
      check($sformatf("walk_col%0d", i), col_n, cv[i].exp_col);
    end

    // Press "5" and check the accept latency edge by edge.
    do_step(4'hF);
    check("p5_col1", col_n, 4'b1101);
    v0 = vcount;
    do_step(4'b1101);
    do_step(4'b1101);
    check("p5_deb_held", key_held, 1'b0);
    check("p5_deb_col", col_n, 4'b1101);
    check("p5_deb_valid", vcount, v0);
    row_n = 4'b1101;
    repeat (4) @(negedge clk);
    step_idx++;
    sclk = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("p5_lat%0d", k), key_valid, (k == 4) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    check("p5_code", key_code, 4'h5);
    check("p5_held", key_held, 1'b1);
    check("p5_valid_cnt", vcount, v0 + 1);

    // Release with a glitch restarting the release count.
    do_step(4'hF);
    do_step(4'hF);
    do_step(4'b1101);
    check("rel_glitch_held", key_held, 1'b1);
    do_step(4'hF);
    do_step(4'hF);
    check("rel_2of3_held", key_held, 1'b1);
    do_step(4'hF);
    check("rel_done_held", key_held, 1'b0);
    check("rel_col2", col_n, 4'b1011);
    check("rel_code_kept", key_code, 4'h5);
    check("rel_valid_cnt", vcount, v0 + 1);

    // Bounce on "9": two steps present, then gone.
    do_step(4'b1011);
    do_step(4'b1011);
    check("b9_col_frozen", col_n, 4'b1011);
    do_step(4'hF);
    check("b9_col3", col_n, 4'b0111);
    check("b9_held", key_held, 1'b0);
    check("b9_valid_cnt", vcount, v0 + 1);

    // Two rows low on column 3 is a ghost and must never be accepted.
    for (int i = 0; i < 8; i++) begin
      do_step((col_n == 4'b0111) ? 4'b1100 : 4'hF);
    end
    check("ghost_valid_cnt", vcount, v0 + 1);
    check("ghost_held", key_held, 1'b0);
    check("ghost_col", col_n, 4'b0111);
    check("ghost_code", key_code, 4'h5);

    // Reset mid-debounce of "1": press has to re-debounce from zero.
    do_step(4'hF);
    do_step(key_rows(0, 0));
    do_step(key_rows(0, 0));
    do_reset();
    check("mid_rst_col", col_n, 4'b1110);
    check("mid_rst_code", key_code, 4'h0);
    check("mid_rst_held", key_held, 1'b0);
    v0 = vcount;
    do_step(key_rows(0, 0));
    do_step(key_rows(0, 0));
    check("mid_rst_redeb_held", key_held, 1'b0);
    check("mid_rst_redeb_valid", vcount, v0);
    do_step(key_rows(0, 0));
    check("mid_rst_acc_held", key_held, 1'b1);
    check("mid_rst_acc_code", key_code, 4'h1);
    check("mid_rst_acc_valid", vcount, v0 + 1);
    for (int i = 0; i < 3; i++) do_step(4'hF);
    check("mid_rst_rel_held", key_held, 1'b0);

    // Full key map.
    for (int i = 0; i < 16; i++) begin
      v0 = vcount;
      n = 0;
      while (key_held !== 1'b1 && n < 16) begin
        do_step(key_rows(km[i].kc, km[i].kr));
        n++;
      end
      check($sformatf("map%0d_held", i), key_held, 1'b1);
      check($sformatf("map%0d_code", i), key_code, km[i].code);
      check($sformatf("map%0d_valid", i), vcount, v0 + 1);
      for (int j = 0; j < 3; j++) do_step(4'hF);
      check($sformatf("map%0d_rel", i), key_held, 1'b0);
    end

    // Hold "D" for 30 steps after acceptance.
    v0 = vcount;
    qstart = vsteps.size();
    n = 0;
    while (key_held !== 1'b1 && n < 16) begin
      do_step(key_rows(3, 3));
      n++;
    end
    acc = step_idx;
    check("hold_d_held", key_held, 1'b1);
    for (int i = 0; i < 30; i++) do_step(key_rows(3, 3));
    check("hold_d_code", key_code, 4'hD);
`ifdef KEY_REPEAT_EN
    check("rpt_count", vcount - v0, 7);
    for (int i = 0; i < 7; i++) begin
      if (qstart + i < vsteps.size()) begin
        check($sformatf("rpt_step%0d", i), vsteps[qstart + i] - acc, rpt_exp[i]);
      end else begin
        checks++;
        failures++;
        $display("FAIL rpt_step%0d: got no pulse expected one at offset %0d", i, rpt_exp[i]);
      end
    end
`else
    check("norpt_count", vcount - v0, 1);
    if (qstart < vsteps.size()) check("norpt_step", vsteps[qstart] - acc, rpt_exp[0]);
`endif
    for (int i = 0; i < 3; i++) do_step(4'hF);
    check("hold_d_rel", key_held, 1'b0);
    check("hold_d_code_kept", key_code, 4'hD);

    check("no_back_to_back_valid", double_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
